// File: rtl/wb_slave_mux.sv
// -----------------------------------------------------------------------------
// wb_slave_mux
//
// Single-master, multi-slave Wishbone address decoder and router. Each master
// transfer is decoded on m_addr_i[SEL_LSB +: SEL_W] and forwarded to exactly
// one of NUM_SLAVES slaves. A per-transfer watchdog aborts a transfer whose
// slave does not ack within TIMEOUT_CYC cycles. Unmapped and timed-out
// transfers complete with a normal ack carrying ERR_DATA, because the upstream
// bridge has no err line.
//
// Optional build macro: WB_MUX_ERR_STATUS_EN adds a sticky error flag with
// the first offending address (err_o, err_addr_o) and a clear input
// (err_clr_i).
//
// Ports:
//   wb_clk_i, rst_ni      clock, asynchronous active-low reset
//   m_cyc_i, m_stb_i      master cycle / strobe
//   m_addr_i, m_wdata_i   master word address / write data
//   m_we_i, m_sel_i       master write enable / byte enables
//   m_rdata_o, m_ack_o    read data and single-cycle ack to the master
//   s_addr_o, s_wdata_o   registered address / write data shared by all slaves
//   s_we_o, s_sel_o       registered write enable / byte enables
//   s_cyc_o, s_stb_o      per-slave cycle / strobe (one-hot while ACTIVE)
//   s_rdata_i             packed slave read data, slave i at [i*DATA_W +: DATA_W]
//   s_ack_i               per-slave ack
//   err_clr_i, err_o,     (WB_MUX_ERR_STATUS_EN only) error clear, sticky
//   err_addr_o            error flag and first error address
// -----------------------------------------------------------------------------
module wb_slave_mux #(
    parameter int                 ADDR_W      = 32,
    parameter int                 DATA_W      = 32,
    parameter int                 NUM_SLAVES  = 4,
    parameter int                 SEL_LSB     = 16,
    parameter int                 SEL_W       = 2,
    parameter int                 TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0]  ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                         wb_clk_i,
    input  logic                         rst_ni,
    input  logic                         m_cyc_i,
    input  logic                         m_stb_i,
    input  logic [ADDR_W-1:0]            m_addr_i,
    input  logic [DATA_W-1:0]            m_wdata_i,
    input  logic                         m_we_i,
    input  logic [DATA_W/8-1:0]          m_sel_i,
    output logic [DATA_W-1:0]            m_rdata_o,
    output logic                         m_ack_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W-1:0]            s_wdata_o,
    output logic                         s_we_o,
    output logic [DATA_W/8-1:0]          s_sel_o,
    output logic [NUM_SLAVES-1:0]        s_cyc_o,
    output logic [NUM_SLAVES-1:0]        s_stb_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i
`ifdef WB_MUX_ERR_STATUS_EN
    ,
    input  logic                         err_clr_i,
    output logic                         err_o,
    output logic [ADDR_W-1:0]            err_addr_o
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // 16 bits covers the full TIMEOUT_CYC range of 1..65535.
    localparam int              CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    // One-hot slave select; it doubles as the latched slave index and drives
    // both s_cyc_o and s_stb_o, so it is nonzero only while ACTIVE.
    logic [NUM_SLAVES-1:0] r_cyc;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_we;
    logic [DATA_W/8-1:0]   r_sel;
    logic [DATA_W-1:0]     r_rdata;

    logic                  w_req;
    logic [SEL_W-1:0]      w_idx;
    logic                  w_mapped;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic                  w_ack;
    logic                  w_timeout;
    logic [DATA_W-1:0]     w_rdata_sel;

    assign w_req     = m_cyc_i & m_stb_i;
    assign w_idx     = m_addr_i[SEL_LSB +: SEL_W];
    // One extra bit so NUM_SLAVES == 2**SEL_W compares correctly.
    assign w_mapped  = ({1'b0, w_idx} < (SEL_W + 1)'(NUM_SLAVES));
    assign w_onehot  = NUM_SLAVES'(1) << w_idx;
    // Masking with the one-hot select ignores acks from every other slave,
    // and late acks once the strobe has dropped.
    assign w_ack     = |(s_ack_i & r_cyc);
    assign w_timeout = (r_cnt == CNT_LAST);

    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_cyc[i]) begin
                w_rdata_sel = s_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cyc   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= m_addr_i;
                        r_wdata <= m_wdata_i;
                        r_we    <= m_we_i;
                        r_sel   <= m_sel_i;
                        if (w_mapped) begin
                            r_cyc   <= w_onehot;
                            r_cnt   <= '0;
                            r_state <= ST_ACTIVE;
                        end else begin
                            r_rdata <= ERR_DATA;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Ack is tested before the watchdog, so an ack in the
                    // timeout cycle is a normal completion.
                    if (w_ack) begin
                        r_cyc <= '0;
                        if (!r_we) begin
                            r_rdata <= w_rdata_sel;
                        end
                        r_we    <= 1'b0;
                        r_sel   <= '0;
                        r_state <= ST_RESP;
                    end else if (w_timeout) begin
                        r_cyc   <= '0;
                        r_rdata <= ERR_DATA;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RESP lasts exactly one cycle, so the ack is a one-cycle pulse by
    // construction and drops asynchronously with reset.
    assign m_ack_o   = (r_state == ST_RESP);
    assign m_rdata_o = r_rdata;
    assign s_addr_o  = r_addr;
    assign s_wdata_o = r_wdata;
    assign s_we_o    = r_we;
    assign s_sel_o   = r_sel;
    assign s_cyc_o   = r_cyc;
    assign s_stb_o   = r_cyc;

`ifdef WB_MUX_ERR_STATUS_EN
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;
    logic              w_err_set;
    logic [ADDR_W-1:0] w_err_addr;

    assign w_err_set  = ((r_state == ST_IDLE) && w_req && !w_mapped) ||
                        ((r_state == ST_ACTIVE) && !w_ack && w_timeout);
    // In IDLE the address is still only on the master inputs.
    assign w_err_addr = (r_state == ST_IDLE) ? m_addr_i : r_addr;

    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_err_set) begin
            // A simultaneous clear discards the old error, so the new one
            // becomes the first error.
            r_err <= 1'b1;
            if (!r_err || err_clr_i) begin
                r_err_addr <= w_err_addr;
            end
        end else if (err_clr_i) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end
    end

    assign err_o      = r_err;
    assign err_addr_o = r_err_addr;
`endif

endmodule

// File: tb/tb_wb_slave_mux.sv
// -----------------------------------------------------------------------------
// tb_wb_slave_mux
//
// Self-checking bench for wb_slave_mux. The main instance has four slaves and
// an 8-cycle watchdog; a second instance with three slaves exercises the
// unmapped decode path. Inputs are driven and outputs sampled on the falling
// clock edge; cycle 0 is the cycle in which the master request is presented.
// -----------------------------------------------------------------------------
module tb_wb_slave_mux;

    localparam int          NS      = 4;
    localparam int          TO      = 8;
    localparam int          XFER_CY = 14;
    localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_sel = '0;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic [31:0] s_addr, s_wdata;
    logic        s_we;
    logic [3:0]  s_sel, s_cyc, s_stb;
    logic [127:0] s_rdata = '0;
    logic [3:0]  s_ack = '0;

    logic        u_cyc = 1'b0, u_stb = 1'b0;
    logic [31:0] u_rdata, u_s_addr, u_s_wdata;
    logic        u_ack, u_s_we;
    logic [3:0]  u_s_sel;
    logic [2:0]  u_s_cyc, u_s_stb;
    logic [95:0] u_s_rdata = '0;
    logic [2:0]  u_s_ack = '0;

`ifdef WB_MUX_ERR_STATUS_EN
    logic        err, u_err;
    logic [31:0] err_addr, u_err_addr;
    logic        err_clr = 1'b0, u_err_clr = 1'b0;
`endif

    wb_slave_mux #(.NUM_SLAVES(NS), .TIMEOUT_CYC(TO)) dut (
        .wb_clk_i(clk), .rst_ni(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_addr_i(m_addr),
        .m_wdata_i(m_wdata), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_rdata_o(m_rdata), .m_ack_o(m_ack),
        .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_rdata_i(s_rdata), .s_ack_i(s_ack)
`ifdef WB_MUX_ERR_STATUS_EN
        , .err_clr_i(err_clr), .err_o(err), .err_addr_o(err_addr)
`endif
    );

    wb_slave_mux #(.NUM_SLAVES(3), .TIMEOUT_CYC(TO)) dut_u (
        .wb_clk_i(clk), .rst_ni(rst_n),
        .m_cyc_i(u_cyc), .m_stb_i(u_stb), .m_addr_i(m_addr),
        .m_wdata_i(m_wdata), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_rdata_o(u_rdata), .m_ack_o(u_ack),
        .s_addr_o(u_s_addr), .s_wdata_o(u_s_wdata), .s_we_o(u_s_we), .s_sel_o(u_s_sel),
        .s_cyc_o(u_s_cyc), .s_stb_o(u_s_stb), .s_rdata_i(u_s_rdata), .s_ack_i(u_s_ack)
`ifdef WB_MUX_ERR_STATUS_EN
        , .err_clr_i(u_err_clr), .err_o(u_err), .err_addr_o(u_err_addr)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One transfer: stimulus, slave behaviour and expected outcome.
    // lat: slave acks at cycle 1+lat if it still sees its strobe (-1 = never).
    // late: cycle of an unconditional ack from the selected slave (-1 = none).
    // noise acks from other slaves are driven at cycles n0 and n1.
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          lat;
        int          late;
        logic [3:0]  noise;
        int          n0;
        int          n1;
        logic [31:0] rd;
        int          exp_cyc;
        logic [31:0] exp_data;
        logic [3:0]  exp_stb1;
    } vec_t;

    typedef struct {
        int          n_ack;
        int          ack_cyc;
        logic [31:0] data;
        logic [3:0]  stb1;
        logic [31:0] addr1;
        logic [31:0] wdata1;
        logic        we1;
        logic [3:0]  sel1;
        logic [3:0]  stb_end;
    } res_t;

    task automatic run_xfer(input vec_t v, output res_t r);
        int idx;
        idx       = int'(v.addr[17:16]);
        r.n_ack   = 0;
        r.ack_cyc = -1;
        r.data    = '0;
        r.stb1    = '0;
        r.addr1   = '0;
        r.wdata1  = '0;
        r.we1     = 1'b0;
        r.sel1    = '0;
        for (int j = 0; j < NS; j++) begin
            s_rdata[j*32 +: 32] = (j == idx) ? v.rd : (32'hBAD0_0000 | 32'(j));
        end
        @(negedge clk);
        m_addr  = v.addr;
        m_we    = v.we;
        m_wdata = v.wdata;
        m_sel   = v.sel;
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
        for (int c = 1; c <= XFER_CY; c++) begin
            @(negedge clk);
            if (c == 1) begin
                r.stb1   = s_stb;
                r.addr1  = s_addr;
                r.wdata1 = s_wdata;
                r.we1    = s_we;
                r.sel1   = s_sel;
            end
            if (m_ack) begin
                r.n_ack++;
                if (r.ack_cyc < 0) begin
                    r.ack_cyc = c;
                    r.data    = m_rdata;
                end
                m_cyc = 1'b0;
                m_stb = 1'b0;
            end
            s_ack = '0;
            if (v.lat >= 0 && c == 1 + v.lat && s_stb[idx]) s_ack[idx] = 1'b1;
            if (c == v.late) s_ack[idx] = 1'b1;
            if (c == v.n0 || c == v.n1) s_ack = s_ack | v.noise;
        end
        r.stb_end = s_stb;
        s_ack = '0;
        m_cyc = 1'b0;
        m_stb = 1'b0;
    endtask

    task automatic check_vec(input string tag, input vec_t v, input res_t r);
        check({tag, ".ack_count"}, 64'(r.n_ack), 64'(1));
        check({tag, ".ack_cycle"}, 64'(r.ack_cyc), 64'(v.exp_cyc));
        check({tag, ".rdata"}, 64'(r.data), 64'(v.exp_data));
        check({tag, ".stb_c1"}, 64'(r.stb1), 64'(v.exp_stb1));
        check({tag, ".s_addr"}, 64'(r.addr1), 64'(v.addr));
        check({tag, ".s_wdata"}, 64'(r.wdata1), 64'(v.wdata));
        check({tag, ".s_we_sel"}, 64'({r.we1, r.sel1}), 64'({v.we, v.sel}));
        check({tag, ".stb_after"}, 64'(r.stb_end), 64'(0));
    endtask

    vec_t        vecs[8];
    vec_t        v;
    res_t        r;
    logic [31:0] model_rdata;
    int          ridx;

    initial begin
        //         addr          we    wdata          sel      lat late noise   n0 n1 rd             cyc data           stb1
        vecs[0] = '{32'h0001_0004, 1'b0, 32'h0,         4'hF,    0, -1, 4'b0000, -1, -1, 32'h1234_5678, 2, 32'h1234_5678, 4'b0010};
        vecs[1] = '{32'h0003_0010, 1'b1, 32'hA5A5_A5A5, 4'b0011, 5, -1, 4'b0000, -1, -1, 32'h0BAD_0001, 7, 32'h1234_5678, 4'b1000};
        vecs[2] = '{32'h0000_0020, 1'b0, 32'h0,         4'hF,   -1, 12, 4'b0000, -1, -1, 32'h1111_1111, 9, ERR,           4'b0001};
        vecs[3] = '{32'h0002_0000, 1'b0, 32'h0,         4'hF,    3, -1, 4'b0001,  2,  4, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 4'b0100};
        vecs[4] = '{32'h0001_0100, 1'b0, 32'h0,         4'hF,    7, -1, 4'b0000, -1, -1, 32'h7777_0007, 9, 32'h7777_0007, 4'b0010};
        vecs[5] = '{32'h0003_0200, 1'b0, 32'h0,         4'hF,    8, -1, 4'b0000, -1, -1, 32'h8888_0008, 9, ERR,           4'b1000};
        vecs[6] = '{32'h0000_0300, 1'b1, 32'h0F0F_0F0F, 4'b1100, 8, -1, 4'b0000, -1, -1, 32'h6666_0006, 9, ERR,           4'b0001};
        vecs[7] = '{32'h0002_0400, 1'b1, 32'h1212_1212, 4'b1111, 2, -1, 4'b1011,  3,  3, 32'h5555_0005, 4, ERR,           4'b0100};

        // Reset state.
        #12;
        check("rst.m_ack", 64'(m_ack), 64'(0));
        check("rst.m_rdata", 64'(m_rdata), 64'(0));
        check("rst.s_cyc_stb", 64'({s_cyc, s_stb}), 64'(0));
        check("rst.s_addr_wdata", 64'({s_addr, s_wdata}), 64'(0));
        check("rst.s_we_sel", 64'({s_we, s_sel}), 64'(0));
        check("rst.u_ack", 64'(u_ack), 64'(0));
`ifdef WB_MUX_ERR_STATUS_EN
        check("rst.err", 64'({err, err_addr}), 64'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i], r);
            check_vec($sformatf("vec%0d", i), vecs[i], r);
        end
`ifdef WB_MUX_ERR_STATUS_EN
        check("vec.err_sticky", 64'(err), 64'(1));
        check("vec.err_first_addr", 64'(err_addr), 64'(32'h0000_0020));
`endif

        // Randomised transfers against the reference model: a slave answering
        // at cycle k completes at k+1 if k <= TO, otherwise the watchdog
        // answers at cycle TO+1 with ERR. Writes leave the read data alone.
        model_rdata = vecs[7].exp_data;
        for (int n = 0; n < 40; n++) begin
            ridx       = $urandom_range(0, NS - 1);
            v.addr     = $urandom;
            v.addr[17:16] = 2'(ridx);
            v.we       = 1'($urandom_range(0, 1));
            v.wdata    = $urandom;
            v.sel      = 4'($urandom_range(0, 15));
            v.lat      = $urandom_range(0, 9);
            v.late     = -1;
            v.noise    = 4'($urandom_range(0, 15)) & ~(4'b0001 << ridx);
            v.n0       = $urandom_range(1, 10);
            v.n1       = $urandom_range(1, 10);
            v.rd       = $urandom;
            if (v.lat + 1 <= TO) begin
                v.exp_cyc = v.lat + 2;
                if (!v.we) model_rdata = v.rd;
            end else begin
                v.exp_cyc   = TO + 1;
                model_rdata = ERR;
            end
            v.exp_data = model_rdata;
            v.exp_stb1 = 4'b0001 << ridx;
            run_xfer(v, r);
            check_vec($sformatf("rnd%0d", n), v, r);
        end

        // Reset while ACTIVE: strobes and ack drop without a clock edge.
        @(negedge clk);
        m_addr = 32'h0000_0040;
        m_we   = 1'b0;
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        repeat (3) @(negedge clk);
        check("mid.stb_active", 64'(s_stb), 64'(4'b0001));
        #1 rst_n = 1'b0;
        #1;
        check("mid.cyc_stb_dropped", 64'({s_cyc, s_stb}), 64'(0));
        check("mid.m_ack", 64'(m_ack), 64'(0));
        m_cyc = 1'b0;
        m_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        v = '{32'h0001_0050, 1'b0, 32'h0, 4'hF, 1, -1, 4'b0000, -1, -1,
              32'h0102_0304, 3, 32'h0102_0304, 4'b0010};
        run_xfer(v, r);
        check_vec("post_rst", v, r);

        // Unmapped slave index on the three-slave instance.
        @(negedge clk);
        m_addr = 32'h1233_0040;
        m_we   = 1'b0;
        u_cyc  = 1'b1;
        u_stb  = 1'b1;
        @(negedge clk);
        check("unmap.ack_c1", 64'(u_ack), 64'(1));
        check("unmap.rdata", 64'(u_rdata), 64'(ERR));
        check("unmap.no_stb", 64'({u_s_cyc, u_s_stb}), 64'(0));
`ifdef WB_MUX_ERR_STATUS_EN
        check("unmap.err", 64'(u_err), 64'(1));
        check("unmap.err_addr", 64'(u_err_addr), 64'(32'h1233_0040));
`endif
        u_cyc = 1'b0;
        u_stb = 1'b0;
        @(negedge clk);
        check("unmap.ack_c2", 64'(u_ack), 64'(0));
`ifdef WB_MUX_ERR_STATUS_EN
        check("unmap.err_held", 64'(u_err), 64'(1));
        u_err_clr = 1'b1;
        @(negedge clk);
        u_err_clr = 1'b0;
        check("unmap.err_cleared", 64'({u_err, u_err_addr}), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
